// File: rtl/init_sequencer.sv
// rtl/init_sequencer.sv - table-driven RTC register init sequencer
// Walks N_STEPS (address,data) pairs, holding each for HOLD bus-ready cycles.
module init_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int N_STEPS  = 2,
  parameter int HOLD     = 36,
  parameter     SEQ_ADDR = {8'h02, 8'h02},
  parameter     SEQ_DATA = {8'h00, 8'h08},
  localparam int SW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_mod,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     step_idx
);

  localparam int CW = $clog2(HOLD + 1);

  if (N_STEPS < 1) begin : g_bad_steps
    $error("init_sequencer: N_STEPS must be >= 1");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("init_sequencer: HOLD must be >= 1");
  end
  if ($bits(SEQ_ADDR) != N_STEPS * ADDR_W) begin : g_bad_addr_tbl
    $error("init_sequencer: SEQ_ADDR width must be N_STEPS*ADDR_W");
  end
  if ($bits(SEQ_DATA) != N_STEPS * DATA_W) begin : g_bad_data_tbl
    $error("init_sequencer: SEQ_DATA width must be N_STEPS*DATA_W");
  end

  localparam logic [N_STEPS*ADDR_W-1:0] ADDR_TBL = SEQ_ADDR;
  localparam logic [N_STEPS*DATA_W-1:0] DATA_TBL = SEQ_DATA;
  localparam logic [CW-1:0]             CNT_LAST = CW'(HOLD - 1);
  localparam logic [SW-1:0]             LAST_IDX = SW'(N_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       step_q, step_d, step_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  function automatic logic [ADDR_W-1:0] addr_at(input logic [SW-1:0] idx);
    addr_at = '0;
    for (int k = 0; k < N_STEPS; k++)
      if (k == int'(idx)) addr_at = ADDR_TBL[k*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] data_at(input logic [SW-1:0] idx);
    data_at = '0;
    for (int k = 0; k < N_STEPS; k++)
      if (k == int'(idx)) data_at = DATA_TBL[k*DATA_W +: DATA_W];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    step_nxt = step_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          step_d  = '0;
          addr_d  = addr_at('0);
          data_d  = data_at('0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          step_d  = '0;
          addr_d  = '0;
          data_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (bus_ready) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            // Next entry is loaded on the boundary edge itself, so steps abut with no gap.
            if (step_q != LAST_IDX) begin
              step_d = step_nxt;
              addr_d = addr_at(step_nxt);
              data_d = data_at(step_nxt);
            end else if (loop) begin
              step_d = '0;
              addr_d = addr_at('0);
              data_d = data_at('0);
            end else begin
              state_d = S_DONE;
              step_d  = '0;
              addr_d  = '0;
              data_d  = '0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign address  = addr_q;
  assign data_mod = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_init_sequencer.sv
// tb/tb_init_sequencer.sv - bench for init_sequencer
// Two instances (default table, and N_STEPS=1/HOLD=1) share stimulus; model counts ready cycles per pass.
module tb_init_sequencer;

  logic clk = 1'b0;
  logic reset, start, abort, loop, bus_ready;
  always #5 clk = ~clk;

  logic [7:0] a0, d0, a1, d1;
  logic       v0, b0, dn0, v1, b1, dn1;
  logic [0:0] s0, s1;

  init_sequencer u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
    .bus_ready(bus_ready), .address(a0), .data_mod(d0), .valid(v0),
    .busy(b0), .done(dn0), .step_idx(s0)
  );

  init_sequencer #(.N_STEPS(1), .HOLD(1), .SEQ_ADDR(8'h5A), .SEQ_DATA(8'hC3)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
    .bus_ready(bus_ready), .address(a1), .data_mod(d1), .valid(v1),
    .busy(b1), .done(dn1), .step_idx(s1)
  );

  logic [19:0] got [2];
  assign got[0] = {v0, b0, dn0, a0, d0, s0};
  assign got[1] = {v1, b1, dn1, a1, d1, s1};

  int tests = 0;
  int failed = 0;

  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;
  int        m_phase [2] = '{P_IDLE, P_IDLE};
  int        m_ready [2] = '{0, 0};
  int        P_N [2] = '{2, 1};
  int        P_H [2] = '{36, 1};
  logic [7:0] m_addr [2][2] = '{'{8'h02, 8'h02}, '{8'h5A, 8'h00}};
  logic [7:0] m_data [2][2] = '{'{8'h08, 8'h00}, '{8'hC3, 8'h00}};

  // Step shown = (ready cycles so far / HOLD) mod N; a pass ends every N*HOLD ready cycles.
  function automatic logic [19:0] exp_vec(input int i);
    int s;
    if (m_phase[i] == P_RUN) begin
      s = (m_ready[i] / P_H[i]) % P_N[i];
      return {1'b1, 1'b1, 1'b0, m_addr[i][s], m_data[i][s], 1'(s)};
    end else if (m_phase[i] == P_DONE) begin
      return {3'b001, 17'd0};
    end
    return 20'd0;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = P_IDLE;
        m_ready[i] = 0;
      end else begin
        case (m_phase[i])
          P_IDLE: if (start) begin m_phase[i] = P_RUN; m_ready[i] = 0; end
          P_RUN: begin
            if (abort) m_phase[i] = P_IDLE;
            else if (bus_ready) begin
              m_ready[i] = (m_ready[i] + 1) % (P_N[i] * P_H[i]);
              if (m_ready[i] == 0 && !loop) m_phase[i] = P_DONE;
            end
          end
          default: m_phase[i] = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clean_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0; bus_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; loop = 1'b0; bus_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got[i] !== 20'd0) begin
        failed++;
        $display("FAIL reset inst%0d got=%h exp=%h", i, got[i], 20'd0);
      end
    end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_basic(input bit extra_starts, input string name);
    int n08, n00, ndone, done_edge;
    n08 = 0; n00 = 0; ndone = 0; done_edge = -1;
    clean_reset();
    start = 1'b1;
    for (int e = 0; e <= 90; e++) begin
      tick();
      start = extra_starts && (e + 1 == 10 || e + 1 == 73);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got[i] !== exp_vec(i)) begin
          failed++;
          $display("FAIL %s inst%0d edge%0d got=%h exp=%h", name, i, e, got[i], exp_vec(i));
        end
      end
      if (v0 && d0 == 8'h08) n08++;
      if (v0 && d0 == 8'h00) n00++;
      if (dn0) begin ndone++; if (done_edge < 0) done_edge = e; end
    end
    tests++;
    if (n08 != 36 || n00 != 36) begin
      failed++;
      $display("FAIL %s_step_len got=%0d/%0d exp=36/36", name, n08, n00);
    end
    tests++;
    if (ndone != 1 || done_edge != 72) begin
      failed++;
      $display("FAIL %s_done got count=%0d edge=%0d exp count=1 edge=72", name, ndone, done_edge);
    end
  endtask

  task automatic test_stall();
    int n08, n00, done_edge;
    n08 = 0; n00 = 0; done_edge = -1;
    clean_reset();
    start = 1'b1;
    for (int e = 0; e <= 95; e++) begin
      tick();
      start = 1'b0;
      bus_ready = !(e + 1 >= 5 && e + 1 <= 14);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got[i] !== exp_vec(i)) begin
          failed++;
          $display("FAIL stall inst%0d edge%0d got=%h exp=%h", i, e, got[i], exp_vec(i));
        end
      end
      if (v0 && d0 == 8'h08) n08++;
      if (v0 && d0 == 8'h00) n00++;
      if (dn0 && done_edge < 0) done_edge = e;
    end
    tests++;
    if (n08 != 46 || n00 != 36 || done_edge != 82) begin
      failed++;
      $display("FAIL stall_timing got=%0d/%0d done@%0d exp=46/36 done@82", n08, n00, done_edge);
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    clean_reset();
    start = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      tick();
      start = 1'b0;
      abort = (e + 1 == 50);
    end
    tests++;
    if ({v0, b0, dn0, a0, d0} !== 19'd0) begin
      failed++;
      $display("FAIL abort_clear got=%h exp=0", {v0, b0, dn0, a0, d0});
    end
    abort = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (dn0) ndone++;
      tests++;
      if (got[0] !== exp_vec(0)) begin
        failed++;
        $display("FAIL abort_idle edge%0d got=%h exp=%h", e, got[0], exp_vec(0));
      end
    end
    tests++;
    if (ndone != 0) begin
      failed++;
      $display("FAIL abort_no_done got=%0d exp=0", ndone);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (!(v0 && s0 == 1'b0 && d0 == 8'h08)) begin
      failed++;
      $display("FAIL abort_restart got v=%0b step=%0d data=%h exp v=1 step=0 data=08", v0, s0, d0);
    end
  endtask

  task automatic test_loop();
    int done_edge;
    done_edge = -1;
    clean_reset();
    loop = 1'b1;
    start = 1'b1;
    for (int e = 0; e <= 200; e++) begin
      tick();
      start = 1'b0;
      if (e + 1 == 100) loop = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got[i] !== exp_vec(i)) begin
          failed++;
          $display("FAIL loop inst%0d edge%0d got=%h exp=%h", i, e, got[i], exp_vec(i));
        end
      end
      if (dn0 && done_edge < 0) done_edge = e;
    end
    tests++;
    if (done_edge != 144) begin
      failed++;
      $display("FAIL loop_done_edge got=%0d exp=144", done_edge);
    end
  endtask

  task automatic test_async_reset();
    clean_reset();
    start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      start = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got[i] !== 20'd0) begin
        failed++;
        $display("FAIL async_reset inst%0d got=%h exp=%h", i, got[i], 20'd0);
      end
    end
    tick();
    reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got[i] !== exp_vec(i) || got[i] !== 20'd0) begin
          failed++;
          $display("FAIL post_reset_idle inst%0d edge%0d got=%h exp=%h", i, e, got[i], 20'd0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit v73, v74;
    clean_reset();
    start = 1'b1;
    for (int e = 0; e <= 160; e++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got[i] !== exp_vec(i)) begin
          failed++;
          $display("FAIL b2b inst%0d edge%0d got=%h exp=%h", i, e, got[i], exp_vec(i));
        end
      end
      if (e == 73) v73 = v0;
      if (e == 74) v74 = v0;
    end
    start = 1'b0;
    tests++;
    if (v73 !== 1'b0 || v74 !== 1'b1) begin
      failed++;
      $display("FAIL b2b_relaunch got v@73=%0b v@74=%0b exp 0/1", v73, v74);
    end
  endtask

  task automatic test_random();
    clean_reset();
    for (int e = 0; e < 4000; e++) begin
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 99) == 0);
      bus_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) loop = ~loop;
      tick();
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got[i] !== exp_vec(i)) begin
          failed++;
          $display("FAIL random inst%0d edge%0d got=%h exp=%h", i, e, got[i], exp_vec(i));
        end
      end
    end
    start = 1'b0; abort = 1'b0; loop = 1'b0; bus_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "ignored_start");
    test_stall();
    test_abort();
    test_loop();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
